voice_alloc: RTL and testbench

VOICE_ALLOC -- requirements
Module: voice_alloc

---
 rtl/voice_alloc.sv | 157 +++++++++++++++
 tb/tb_voice_alloc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note events onto VOICES synth voice gates.
// Optional macro VOICE_STEAL_EN: steal a round-robin voice when every gate is held.
module voice_alloc #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_on,
  input  logic [6:0]         ev_key,
  input  logic [6:0]         ev_vel,
  input  logic               n_xxxx_zero,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);

  typedef enum logic [1:0] {IDLE, SEARCH, HOLD} state_t;

  state_t            state;
  logic              ev_on_r;
  logic [6:0]        ev_key_r;
  logic [6:0]        ev_vel_r;
  logic [2:0]        sync;
  logic              fcnt;
  logic              fall;
`ifdef VOICE_STEAL_EN
  logic [V_WIDTH-1:0] steal_ptr;
`endif

  logic [VOICES-1:0]  hit, free_idle, idle, key_wr;
  logic [VOICES-1:0][6:0] key_tab;
  logic               hit_f, fi_f, id_f, on_f;
  logic [V_WIDTH-1:0] hit_v, fi_v, id_v, on_v;

  // {found, index} of the lowest set bit
  function automatic logic [V_WIDTH:0] lowest(input logic [VOICES-1:0] m);
    logic [V_WIDTH:0] r;
    r = '0;
    for (int i = VOICES-1; i >= 0; i--)
      if (m[i]) r = {1'b1, V_WIDTH'(i)};
    return r;
  endfunction

  // per-voice key table and match flags
  for (genvar g = 0; g < VOICES; g++) begin : g_lane
    always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
      if (!reset_reg_N)   key_tab[g] <= '0;
      else if (key_wr[g]) key_tab[g] <= ev_key_r;
    end
    assign hit[g]       = keys_on[g] & (key_tab[g] == ev_key_r);
    assign free_idle[g] = ~keys_on[g] & voice_free[g];
    assign idle[g]      = ~keys_on[g];
  end

  assign fall = sync[2] & ~sync[1];

  always_comb begin
    {hit_f, hit_v} = lowest(hit);
    {fi_f, fi_v}   = lowest(free_idle);
    {id_f, id_v}   = lowest(idle);
    on_f = 1'b1;
    on_v = '0;
    if (hit_f)     on_v = hit_v;
    else if (fi_f) on_v = fi_v;
    else if (id_f) on_v = id_v;
    else begin
`ifdef VOICE_STEAL_EN
      on_v = steal_ptr;
`else
      on_f = 1'b0;
`endif
    end
    key_wr = '0;
    if (state == SEARCH && ev_on_r && on_f) key_wr[on_v] = 1'b1;
  end

  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state       <= IDLE;
      ev_ready    <= 1'b0;
      ev_on_r     <= 1'b0;
      ev_key_r    <= '0;
      ev_vel_r    <= '0;
      keys_on     <= '0;
      note_on     <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      sync        <= 3'b111;
      fcnt        <= 1'b0;
`ifdef VOICE_STEAL_EN
      steal_ptr   <= '0;
`endif
    end else begin
      sync <= {sync[1:0], n_xxxx_zero};
      case (state)
        IDLE: begin
          if (ev_valid && ev_ready) begin
            // zero-velocity note-on is a note-off
            ev_on_r  <= ev_on & (|ev_vel);
            ev_key_r <= ev_key;
            ev_vel_r <= ev_vel;
            ev_ready <= 1'b0;
            state    <= SEARCH;
          end else begin
            ev_ready <= 1'b1;
          end
        end
        SEARCH: begin
          if (ev_on_r && on_f) begin
            keys_on[on_v] <= 1'b1;
            cur_key_adr   <= on_v;
            cur_key_val   <= {1'b0, ev_key_r};
            cur_vel_on    <= {ev_vel_r, ev_vel_r[6]};
            note_on       <= 1'b1;
            fcnt          <= 1'b0;
            state         <= HOLD;
`ifdef VOICE_STEAL_EN
            if (!hit_f && !id_f)
              steal_ptr <= (steal_ptr == V_WIDTH'(VOICES-1)) ? '0 : steal_ptr + 1'b1;
`endif
          end else begin
            if (!ev_on_r && hit_f) begin
              keys_on[hit_v] <= 1'b0;
              cur_key_adr    <= hit_v;
              cur_vel_off    <= {ev_vel_r, ev_vel_r[6]};
            end
            ev_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        HOLD: begin
          // note_on spans two engine frame markers
          if (fall) begin
            if (fcnt) begin
              note_on  <= 1'b0;
              ev_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              fcnt <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Directed bench for voice_alloc: allocation rules, note-off, frame-stretched strobe, reset.
module tb_voice_alloc;
  logic       OSC_CLK = 1'b0;
  logic       reset_reg_N = 1'b0;
  logic       ev_valid = 1'b0, ev_ready, ev_on = 1'b0;
  logic [6:0] ev_key = '0, ev_vel = '0;
  logic       n_xxxx_zero = 1'b1;
  logic [7:0] voice_free = 8'hFF, keys_on;
  logic       note_on;
  logic [2:0] cur_key_adr;
  logic [7:0] cur_key_val, cur_vel_on, cur_vel_off;
  int tests = 0, fails = 0;

  voice_alloc #(.VOICES(8), .V_WIDTH(3)) dut (
    .OSC_CLK(OSC_CLK), .reset_reg_N(reset_reg_N), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_key(ev_key), .ev_vel(ev_vel), .n_xxxx_zero(n_xxxx_zero),
    .voice_free(voice_free), .keys_on(keys_on), .note_on(note_on), .cur_key_adr(cur_key_adr),
    .cur_key_val(cur_key_val), .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off));

  always #5 OSC_CLK = ~OSC_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one event; returns at the negedge after the SEARCH edge
  task automatic send(input logic on, input logic [6:0] key, input logic [6:0] vel);
    int n = 0;
    @(negedge OSC_CLK);
    while (!ev_ready && n < 100) begin @(negedge OSC_CLK); n++; end
    if (!ev_ready) begin chk("ready_timeout", 0, 1); return; end
    ev_valid = 1'b1; ev_on = on; ev_key = key; ev_vel = vel;
    @(posedge OSC_CLK);
    #1 ev_valid = 1'b0;
    @(posedge OSC_CLK);
    @(negedge OSC_CLK);
  endtask

  task automatic frame();
    n_xxxx_zero = 1'b0;
    repeat (3) @(negedge OSC_CLK);
    n_xxxx_zero = 1'b1;
    repeat (3) @(negedge OSC_CLK);
  endtask

  task automatic hold_done();
    frame(); frame();
  endtask

  task automatic do_reset();
    @(negedge OSC_CLK);
    reset_reg_N = 1'b0;
    voice_free = 8'hFF;
    repeat (2) @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    @(posedge OSC_CLK); #1;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge OSC_CLK);
    chk("rst_ready", ev_ready, 0);
    chk("rst_keys", keys_on, 0);
    chk("rst_note", note_on, 0);
    chk("rst_cur", {cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}, 0);
    reset_reg_N = 1'b1;
    @(posedge OSC_CLK); #1;
    chk("ready_after_rst", ev_ready, 1);

    // frame marker while idle must not count toward the strobe
    frame();
    send(1, 7'd60, 7'd127);
    chk("on60_keys", keys_on, 8'h01);
    chk("on60_adr", cur_key_adr, 0);
    chk("on60_val", cur_key_val, 8'h3C);
    chk("on60_vel", cur_vel_on, 8'hFF);
    chk("on60_note", note_on, 1);
    chk("hold_ready", ev_ready, 0);
    frame();
    chk("note_after_1frame", note_on, 1);
    frame();
    chk("note_after_2frame", note_on, 0);
    chk("ready_after_hold", ev_ready, 1);

    send(1, 7'd64, 7'd100);
    chk("on64_keys", keys_on, 8'h03);
    chk("on64_adr", cur_key_adr, 1);
    hold_done();
    // velocity 64 -> {7'h40, 1} = 8'h81
    send(0, 7'd60, 7'd64);
    chk("off60_keys", keys_on, 8'h02);
    chk("off60_adr", cur_key_adr, 0);
    chk("off60_vel", cur_vel_off, 8'h81);
    chk("off60_note", note_on, 0);
    chk("off60_val_stable", cur_key_val, 8'h40);
    chk("off60_ready", ev_ready, 1);

    // unmatched note-off changes nothing
    send(0, 7'd99, 7'd10);
    chk("off99_keys", keys_on, 8'h02);
    chk("off99_vel", cur_vel_off, 8'h81);
    chk("off99_adr", cur_key_adr, 0);

    // retrigger of held key 64 on voice 1; vel 20 -> 8'h28
    send(1, 7'd64, 7'd20);
    chk("retrig_keys", keys_on, 8'h02);
    chk("retrig_adr", cur_key_adr, 1);
    chk("retrig_note", note_on, 1);
    chk("retrig_vel", cur_vel_on, 8'h28);
    hold_done();

    // free-voice preference: voices 0,1 busy in the engine, 2 free
    do_reset();
    send(1, 7'd60, 7'd90); hold_done();
    send(1, 7'd61, 7'd90); hold_done();
    send(1, 7'd62, 7'd90); hold_done();
    send(0, 7'd60, 7'd1);
    send(0, 7'd61, 7'd1);
    send(0, 7'd62, 7'd1);
    chk("released_keys", keys_on, 8'h00);
    voice_free = 8'b1111_1100;
    send(1, 7'd70, 7'd90);
    chk("free_pick_adr", cur_key_adr, 2);
    chk("free_pick_keys", keys_on, 8'h04);
    hold_done();
    // no engine-free voice: lowest unkeyed gate wins
    voice_free = 8'h00;
    send(1, 7'd71, 7'd90);
    chk("idle_pick_adr", cur_key_adr, 0);
    chk("idle_pick_keys", keys_on, 8'h05);
    hold_done();

    // nine note-ons with distinct keys
    do_reset();
    for (int k = 0; k < 8; k++) begin
      send(1, 7'(70 + k), 7'd90);
      hold_done();
    end
    chk("eight_keys", keys_on, 8'hFF);
    send(1, 7'd80, 7'd90);
`ifdef VOICE_STEAL_EN
    chk("steal_adr", cur_key_adr, 0);
    chk("steal_note", note_on, 1);
    chk("steal_val", cur_key_val, 8'h50);
    hold_done();
    send(1, 7'd81, 7'd90);
    chk("steal2_adr", cur_key_adr, 1);
    hold_done();
`else
    chk("nosteal_keys", keys_on, 8'hFF);
    chk("nosteal_note", note_on, 0);
    chk("nosteal_adr", cur_key_adr, 7);
    chk("nosteal_val", cur_key_val, 8'h4D);
    chk("nosteal_ready", ev_ready, 1);
`endif

    // zero-velocity note-on releases voice 3
    do_reset();
    send(1, 7'd50, 7'd90); hold_done();
    send(1, 7'd51, 7'd90); hold_done();
    send(1, 7'd52, 7'd90); hold_done();
    send(1, 7'd60, 7'd90); hold_done();
    chk("four_keys", keys_on, 8'h0F);
    send(1, 7'd60, 7'd0);
    chk("vel0_keys", keys_on, 8'h07);
    chk("vel0_note", note_on, 0);
    chk("vel0_adr", cur_key_adr, 3);

    // reset pulse during HOLD
    send(1, 7'd10, 7'd90);
    chk("pre_rst_note", note_on, 1);
    reset_reg_N = 1'b0;
    #1;
    chk("rst_hold_keys", keys_on, 0);
    chk("rst_hold_note", note_on, 0);
    chk("rst_hold_cur", {cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}, 0);
    chk("rst_hold_ready", ev_ready, 0);
    @(negedge OSC_CLK);
    reset_reg_N = 1'b1;
    @(posedge OSC_CLK); #1;
    chk("rel_ready", ev_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
